// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM stage / MEM-WB pipeline register.
//   - bit positions inside the MEM and WB control bundles from EX/MEM
//   - encoding of the data-memory access FSM
package mem_pkg;

    localparam int MEM_BRANCH  = 2;
    localparam int MEM_READ    = 1;
    localparam int MEM_WRITE   = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory request/acknowledge bus.
//   dmem_req   master->slave  access in progress
//   dmem_we    master->slave  1=write, 0=read
//   dmem_addr  master->slave  byte address
//   dmem_wdata master->slave  store data
//   dmem_ack   slave->master  completion, dmem_rdata valid in the same cycle
//   dmem_rdata slave->master  load data
interface mem_wb_stage_if #(
    parameter int N = 32
);
    logic         dmem_req;
    logic         dmem_we;
    logic [N-1:0] dmem_addr;
    logic [N-1:0] dmem_wdata;
    logic         dmem_ack;
    logic [N-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: IDLE/WAIT handshake FSM for the data-memory port.
//   clk, rst_n  clock, async active-low reset
//   mem_op      current EX/MEM entry reads or writes memory
//   dmem_ack    memory completion
//   dmem_req    request to memory
//   stall       freeze upstream stages
//   capture     MEM/WB loads the current entry this edge (else a bubble)
module dmem_ctrl
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mem_op,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic stall,
    output logic capture
);

    mem_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        stall    = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                // ack is deliberately ignored here: a request must be seen
                // for at least one cycle before completion is accepted.
                if (mem_op) begin
                    dmem_req = 1'b1;
                    stall    = 1'b1;
                    state_d  = WAIT;
                end else begin
                    capture  = 1'b1;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // While reset is held the state is IDLE but the EX/MEM entry may still
        // be a memory op; force the handshake quiet immediately.
        if (!rst_n) begin
            dmem_req = 1'b0;
            stall    = 1'b0;
            capture  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage plus MEM/WB pipeline register.
//   clk, rst_n        clock, async active-low reset
//   MEM_in, WB_in     EX/MEM control ({Branch,MemRead,MemWrite}, {RegWrite,MemtoReg})
//   Alu, Writedata    ALU result / address, store data
//   loadregout        destination register
//   branchout, zero1  branch target, ALU zero flag
//   dmem              data-memory bus (master side)
//   stall             freeze PC, IF/ID, ID/EX, EX/MEM
//   pcsrc, branch_target  branch redirect
//   WB_out, memdata, aluout_wb, wbreg, wb_data  registered MEM/WB outputs
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            MEM_in,
    input  logic [1:0]            WB_in,
    input  logic [N-1:0]          Alu,
    input  logic [N-1:0]          Writedata,
    input  logic [4:0]            loadregout,
    input  logic [N-1:0]          branchout,
    input  logic                  zero1,
    mem_wb_stage_if.master        dmem,
    output logic                  stall,
    output logic                  pcsrc,
    output logic [N-1:0]          branch_target,
    output logic [1:0]            WB_out,
    output logic [N-1:0]          memdata,
    output logic [N-1:0]          aluout_wb,
    output logic [4:0]            wbreg,
    output logic [N-1:0]          wb_data
);

    logic         mem_op;
    logic         is_read;
    logic         capture;
    logic         req;
    logic [N-1:0] memdata_d;

    assign mem_op  = MEM_in[MEM_READ] | MEM_in[MEM_WRITE];
    // Read+write together is treated as a write, so it never updates memdata.
    assign is_read = MEM_in[MEM_READ] & ~MEM_in[MEM_WRITE];

    dmem_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_op   (mem_op),
        .dmem_ack (dmem.dmem_ack),
        .dmem_req (req),
        .stall    (stall),
        .capture  (capture)
    );

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = MEM_in[MEM_WRITE];
    assign dmem.dmem_addr  = Alu;
    assign dmem.dmem_wdata = Writedata;

    assign pcsrc         = MEM_in[MEM_BRANCH] & zero1 & ~stall;
    assign branch_target = branchout;

    // capture for a read only happens on the ack cycle, so rdata is valid.
    assign memdata_d = is_read ? dmem.dmem_rdata : memdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_out    <= '0;
            memdata   <= '0;
            aluout_wb <= '0;
            wbreg     <= '0;
            wb_data   <= '0;
        end else if (capture) begin
            WB_out    <= WB_in;
            memdata   <= memdata_d;
            aluout_wb <= Alu;
            wbreg     <= loadregout;
            // Select from the values being written, not the old register.
            wb_data   <= WB_in[WB_MEMTOREG] ? memdata_d : Alu;
        end else begin
            // Bubble: kill the control, leave the data fields alone.
            WB_out    <= '0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   MEM_in;
    logic [1:0]   WB_in;
    logic [N-1:0] Alu, Writedata, branchout;
    logic [4:0]   loadregout;
    logic         zero1;
    logic         stall, pcsrc;
    logic [N-1:0] branch_target, memdata, aluout_wb, wb_data;
    logic [1:0]   WB_out;
    logic [4:0]   wbreg;

    int checks = 0;
    int errors = 0;

    mem_wb_stage_if #(.N(N)) bus ();

    mem_wb_stage #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MEM_in        (MEM_in),
        .WB_in         (WB_in),
        .Alu           (Alu),
        .Writedata     (Writedata),
        .loadregout    (loadregout),
        .branchout     (branchout),
        .zero1         (zero1),
        .dmem          (bus.master),
        .stall         (stall),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .WB_out        (WB_out),
        .memdata       (memdata),
        .aluout_wb     (aluout_wb),
        .wbreg         (wbreg),
        .wb_data       (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        MEM_in = 3'b000; WB_in = 2'b00; Alu = '0; Writedata = '0;
        loadregout = '0; branchout = '0; zero1 = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

        // Reset state
        #12;
        chk("rst_WB_out", {30'b0, WB_out}, 32'h0);
        chk("rst_memdata", memdata, 32'h0);
        chk("rst_aluout", aluout_wb, 32'h0);
        chk("rst_wbreg", {27'b0, wbreg}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_req", {31'b0, bus.dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        rst_n = 1'b1;
        tick();

        // R-type passthrough
        WB_in = 2'b10; MEM_in = 3'b000; Alu = 32'h1234; loadregout = 5'd5;
        #1 chk("r_stall", {31'b0, stall}, 32'h0);
        chk("r_req", {31'b0, bus.dmem_req}, 32'h0);
        tick();
        chk("r_WB_out", {30'b0, WB_out}, 32'h2);
        chk("r_aluout", aluout_wb, 32'h1234);
        chk("r_wbreg", {27'b0, wbreg}, 32'h5);
        chk("r_wb_data", wb_data, 32'h1234);

        // Load, ack on the 3rd WAIT cycle
        MEM_in = 3'b010; WB_in = 2'b11; Alu = 32'h40; loadregout = 5'd7;
        #1 chk("ld_c1_req", {31'b0, bus.dmem_req}, 32'h1);
        chk("ld_c1_stall", {31'b0, stall}, 32'h1);
        chk("ld_c1_we", {31'b0, bus.dmem_we}, 32'h0);
        chk("ld_c1_addr", bus.dmem_addr, 32'h40);
        tick();
        chk("ld_c2_stall", {31'b0, stall}, 32'h1);
        chk("ld_c2_req", {31'b0, bus.dmem_req}, 32'h1);
        chk("ld_c2_bubble", {30'b0, WB_out}, 32'h0);
        chk("ld_c2_alu_held", aluout_wb, 32'h1234);
        tick();
        chk("ld_c3_stall", {31'b0, stall}, 32'h1);
        chk("ld_c3_addr", bus.dmem_addr, 32'h40);
        chk("ld_c3_bubble", {30'b0, WB_out}, 32'h0);
        tick();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
        #1 chk("ld_ack_stall", {31'b0, stall}, 32'h0);
        chk("ld_ack_req", {31'b0, bus.dmem_req}, 32'h1);
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        chk("ld_memdata", memdata, 32'hDEADBEEF);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_WB_out", {30'b0, WB_out}, 32'h3);
        chk("ld_wbreg", {27'b0, wbreg}, 32'h7);

        // Store, ack after 1 cycle; rdata on the bus must be ignored
        MEM_in = 3'b001; WB_in = 2'b00; Alu = 32'h80; Writedata = 32'hA5A5A5A5;
        #1 chk("st_we", {31'b0, bus.dmem_we}, 32'h1);
        chk("st_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
        chk("st_stall", {31'b0, stall}, 32'h1);
        tick();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h12345678;
        #1 chk("st_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        bus.dmem_ack = 1'b0;
        chk("st_memdata", memdata, 32'hDEADBEEF);
        chk("st_WB_out", {30'b0, WB_out}, 32'h0);
        chk("st_aluout", aluout_wb, 32'h80);
        chk("st_wb_data", wb_data, 32'h80);

        // Branch taken / not taken
        MEM_in = 3'b100; WB_in = 2'b00; zero1 = 1'b1; branchout = 32'h200;
        #1 chk("br_pcsrc", {31'b0, pcsrc}, 32'h1);
        chk("br_target", branch_target, 32'h200);
        chk("br_stall", {31'b0, stall}, 32'h0);
        chk("br_req", {31'b0, bus.dmem_req}, 32'h0);
        zero1 = 1'b0;
        #1 chk("br_nt_pcsrc", {31'b0, pcsrc}, 32'h0);
        tick();

        // Branch bundled with a load: suppressed while stalled
        MEM_in = 3'b110; zero1 = 1'b1; bus.dmem_rdata = 32'h11111111;
        #1 chk("brld_pcsrc_stall", {31'b0, pcsrc}, 32'h0);
        tick();
        bus.dmem_ack = 1'b1;
        #1 chk("brld_pcsrc_ack", {31'b0, pcsrc}, 32'h1);
        tick();
        bus.dmem_ack = 1'b0;
        chk("brld_memdata", memdata, 32'h11111111);
        chk("brld_wb_data", wb_data, 32'h80);

        // Spurious ack in IDLE with no memory op
        MEM_in = 3'b000; WB_in = 2'b00; zero1 = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
        #1 chk("sp_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("sp_memdata", memdata, 32'h11111111);
        chk("sp_req", {31'b0, bus.dmem_req}, 32'h0);
        // New load with ack still high: IDLE must ignore it
        MEM_in = 3'b010; WB_in = 2'b11;
        #1 chk("sp_idle_ignores_ack", {31'b0, stall}, 32'h1);
        tick();
        chk("sp_wait_ack_done", {31'b0, stall}, 32'h0);
        tick();
        bus.dmem_ack = 1'b0;
        chk("sp_ld_memdata", memdata, 32'hCAFEF00D);

        // Reset mid-access
        MEM_in = 3'b010; WB_in = 2'b11; loadregout = 5'd9;
        tick();
        chk("rm_wait_stall", {31'b0, stall}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rm_req", {31'b0, bus.dmem_req}, 32'h0);
        chk("rm_stall", {31'b0, stall}, 32'h0);
        chk("rm_WB_out", {30'b0, WB_out}, 32'h0);
        chk("rm_memdata", memdata, 32'h0);
        chk("rm_aluout", aluout_wb, 32'h0);
        chk("rm_wbreg", {27'b0, wbreg}, 32'h0);
        chk("rm_wb_data", wb_data, 32'h0);
        #1 rst_n = 1'b1;
        bus.dmem_ack = 1'b1;
        #1 chk("rm_restart_idle", {31'b0, stall}, 32'h1);
        tick();
        chk("rm_wait_ack", {31'b0, stall}, 32'h0);
        bus.dmem_ack = 1'b0;
        MEM_in = 3'b000; WB_in = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
